// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey pipeline stage: XORs each incoming state with the round key
// for the round this stage is tracking, and presents it through a one-entry valid/ready slice.
module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_we,
    input  logic [3:0]   key_addr,
    input  logic [127:0] key_wdata,
    output logic         key_wr_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         busy,
    output logic         seq_err
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [127:0] key_mem [NR+1];
    logic [3:0]   rc;
    logic [3:0]   round_sel;
    logic         accept;
    logic         key_ok;
    logic         first_mismatch;

    assign busy     = (rc != 4'd0);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Any in_first beat, and any beat arriving while idle, restarts the block at round 0.
    assign round_sel      = (in_first || (rc == 4'd0)) ? 4'd0 : rc;
    assign first_mismatch = in_first ? (rc != 4'd0) : (rc == 4'd0);

    // Keys may only change between blocks so a block never sees a mixed schedule.
    assign key_ok = !busy && (key_addr <= LAST_ROUND);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_mem    <= '{default: '0};
            key_wr_err <= 1'b0;
        end else begin
            key_wr_err <= key_we && !key_ok;
            if (key_we && key_ok) begin
                key_mem[key_addr] <= key_wdata;
            end
        end
    end

    // The key read here sees the pre-write value when a write lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc        <= 4'd0;
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= 4'd0;
            out_last  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            seq_err <= accept && first_mismatch;
            if (accept) begin
                rc        <= (round_sel == LAST_ROUND) ? 4'd0 : round_sel + 4'd1;
                out_valid <= 1'b1;
                out_state <= in_state ^ key_mem[round_sel];
                out_round <= round_sel;
                out_last  <= (round_sel == LAST_ROUND);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed self-checking bench for add_round_key_stage with hand-computed expectations.
module tb_add_round_key_stage;

    logic         clk;
    logic         rst;
    logic         key_we;
    logic [3:0]   key_addr;
    logic [127:0] key_wdata;
    logic         key_wr_err;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_first;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
    logic         busy;
    logic         seq_err;

    int tests_run;
    int tests_failed;

    add_round_key_stage #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_we     (key_we),
        .key_addr   (key_addr),
        .key_wdata  (key_wdata),
        .key_wr_err (key_wr_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_first   (in_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .out_round  (out_round),
        .out_last   (out_last),
        .busy       (busy),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic write_key(input logic [3:0] addr, input logic [127:0] data);
        key_we    = 1'b1;
        key_addr  = addr;
        key_wdata = data;
        step();
        key_we    = 1'b0;
    endtask

    task automatic load_keys();
        for (int r = 0; r <= 10; r++) begin
            write_key(4'(r), {16{8'(r)}});
        end
    endtask

    task automatic send_beat(input logic first, input logic [127:0] state);
        in_valid = 1'b1;
        in_first = first;
        in_state = state;
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        tests_run++; if (out_state !== 128'h0) begin tests_failed++; $display("[TB] FAIL reset_out_state got %h want 0", out_state); end
        tests_run++; if (out_round !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_out_round got %0d want 0", out_round); end
        tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_last got %0b want 0", out_last); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        tests_run++; if (key_wr_err !== 1'b0 || seq_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_errs got %0b%0b want 00", key_wr_err, seq_err); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_first_beat();
        write_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
        send_beat(1'b1, 128'h00112233445566778899aabbccddeeff);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL first_valid got %0b want 1", out_valid); end
        tests_run++; if (out_state !== 128'h00102030405060708090a0b0c0d0e0f0) begin tests_failed++; $display("[TB] FAIL first_state got %h want 00102030405060708090a0b0c0d0e0f0", out_state); end
        tests_run++; if (out_round !== 4'd0 || out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL first_round got %0d/%0b want 0/0", out_round, out_last); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL first_busy got %0b want 1", busy); end
        do_reset();
    endtask

    task automatic test_full_block();
        load_keys();
        for (int i = 0; i <= 10; i++) begin
            send_beat(i == 0, 128'h0);
            tests_run++; if (out_valid !== 1'b1 || out_round !== 4'(i)) begin tests_failed++; $display("[TB] FAIL block_round%0d got v=%0b r=%0d want v=1 r=%0d", i, out_valid, out_round, i); end
            tests_run++; if (out_state !== {16{8'(i)}}) begin tests_failed++; $display("[TB] FAIL block_state%0d got %h want %h", i, out_state, {16{8'(i)}}); end
            tests_run++; if (out_last !== (i == 10)) begin tests_failed++; $display("[TB] FAIL block_last%0d got %0b want %0b", i, out_last, (i == 10)); end
            tests_run++; if (busy !== (i != 10)) begin tests_failed++; $display("[TB] FAIL block_busy%0d got %0b want %0b", i, busy, (i != 10)); end
        end
        step();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL block_idle got v=%0b busy=%0b want 0/0", out_valid, busy); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i <= 4; i++) send_beat(i == 0, 128'h0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_first  = 1'b0;
        in_state  = {16{8'hf0}};
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_in_ready got %0b want 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++; if (out_valid !== 1'b1 || out_round !== 4'd4 || out_state !== {16{8'h04}}) begin tests_failed++; $display("[TB] FAIL stall_hold%0d got v=%0b r=%0d s=%h want 1/4/04..", k, out_valid, out_round, out_state); end
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_ready%0d got %0b want 0", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_in_ready got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        tests_run++; if (out_round !== 4'd5 || out_state !== {16{8'hf5}}) begin tests_failed++; $display("[TB] FAIL release_beat got r=%0d s=%h want 5/f5..", out_round, out_state); end
        for (int i = 6; i <= 10; i++) begin
            send_beat(1'b0, 128'h0);
            tests_run++; if (out_round !== 4'(i)) begin tests_failed++; $display("[TB] FAIL after_stall_round got %0d want %0d", out_round, i); end
        end
    endtask

    task automatic test_key_protect();
        send_beat(1'b1, 128'h0);
        write_key(4'd3, {128{1'b1}});
        tests_run++; if (key_wr_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_write_err got %0b want 1", key_wr_err); end
        step();
        tests_run++; if (key_wr_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_write_err_pulse got %0b want 0", key_wr_err); end
        for (int i = 1; i <= 10; i++) send_beat(1'b0, 128'h0);
        write_key(4'd12, {128{1'b1}});
        tests_run++; if (key_wr_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL range_write_err got %0b want 1", key_wr_err); end
        step();
        tests_run++; if (key_wr_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL range_write_err_pulse got %0b want 0", key_wr_err); end
        for (int i = 0; i <= 3; i++) send_beat(i == 0, 128'h0);
        tests_run++; if (out_round !== 4'd3 || out_state !== {16{8'h03}}) begin tests_failed++; $display("[TB] FAIL key3_readback got r=%0d s=%h want 3/03..", out_round, out_state); end
    endtask

    task automatic test_seq_err();
        send_beat(1'b0, 128'h0);
        send_beat(1'b0, 128'h0);
        tests_run++; if (seq_err !== 1'b0 || out_round !== 4'd5) begin tests_failed++; $display("[TB] FAIL pre_resync got e=%0b r=%0d want 0/5", seq_err, out_round); end
        send_beat(1'b1, 128'h0);
        tests_run++; if (seq_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL resync_seq_err got %0b want 1", seq_err); end
        tests_run++; if (out_round !== 4'd0 || out_state !== 128'h0) begin tests_failed++; $display("[TB] FAIL resync_beat got r=%0d s=%h want 0/0", out_round, out_state); end
        send_beat(1'b0, 128'h0);
        tests_run++; if (out_round !== 4'd1 || out_state !== {16{8'h01}} || seq_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL resync_next got r=%0d s=%h e=%0b want 1/01../0", out_round, out_state, seq_err); end
    endtask

    task automatic test_reset_mid_block();
        for (int i = 2; i <= 7; i++) send_beat(1'b0, 128'h0);
        tests_run++; if (out_valid !== 1'b1 || out_round !== 4'd7) begin tests_failed++; $display("[TB] FAIL mid_round7 got v=%0b r=%0d want 1/7", out_valid, out_round); end
        do_reset();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_state !== 128'h0) begin tests_failed++; $display("[TB] FAIL mid_reset got v=%0b b=%0b s=%h want 0/0/0", out_valid, busy, out_state); end
        send_beat(1'b1, 128'hdeadbeef0123456789abcdeffedcba98);
        tests_run++; if (out_state !== 128'hdeadbeef0123456789abcdeffedcba98 || out_round !== 4'd0 || seq_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_key_beat got s=%h r=%0d e=%0b", out_state, out_round, seq_err); end
        do_reset();
        send_beat(1'b0, 128'h5);
        tests_run++; if (seq_err !== 1'b1 || out_round !== 4'd0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_nonfirst got e=%0b r=%0d b=%0b want 1/0/1", seq_err, out_round, busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_keys();
        for (int i = 0; i <= 10; i++) send_beat(i == 0, 128'h0);
        tests_run++; if (out_last !== 1'b1 || out_round !== 4'd10) begin tests_failed++; $display("[TB] FAIL b2b_last got l=%0b r=%0d want 1/10", out_last, out_round); end
        send_beat(1'b1, 128'h0);
        tests_run++; if (out_valid !== 1'b1 || out_round !== 4'd0 || out_last !== 1'b0 || seq_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_next got v=%0b r=%0d l=%0b e=%0b want 1/0/0/0", out_valid, out_round, out_last, seq_err); end
    endtask

    task automatic test_write_during_accept();
        do_reset();
        key_we    = 1'b1;
        key_addr  = 4'd0;
        key_wdata = {16{8'haa}};
        send_beat(1'b1, {16{8'h11}});
        key_we    = 1'b0;
        tests_run++; if (out_state !== {16{8'h11}} || key_wr_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL same_cycle_old_key got s=%h e=%0b want 11../0", out_state, key_wr_err); end
        send_beat(1'b1, {16{8'h11}});
        tests_run++; if (out_state !== {16{8'hbb}} || seq_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_cycle_new_key got s=%h e=%0b want bb../1", out_state, seq_err); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        key_we    = 1'b0;
        key_addr  = 4'd0;
        key_wdata = '0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        test_reset();
        test_first_beat();
        test_full_block();
        test_backpressure();
        test_key_protect();
        test_seq_err();
        test_reset_mid_block();
        test_back_to_back();
        test_write_during_accept();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
